// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared state type and constants for the PHY DQ burst data path
package phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR_PRE,
        ST_WR_BURST,
        ST_WR_POST,
        ST_RD_WAIT,
        ST_RD_CAP
    } phy_dq_state_t;

    localparam int MIN_CWL   = 2;
    localparam int MIN_CL    = 1;
    localparam int BC4_BEATS = 4;

endpackage

// File: rtl/phy_dbi_lane.sv
// rtl/phy_dbi_lane.sv - combinational data bus inversion encode/decode for one byte lane
module phy_dbi_lane (
    input  logic [7:0] wr_byte,
    output logic [7:0] wr_enc,
    output logic       wr_inv,
    input  logic [7:0] rd_byte,
    input  logic       rd_inv,
    output logic [7:0] rd_dec
);

    logic [3:0] zeros;

    always_comb begin
        zeros = 4'd0;
        for (int i = 0; i < 8; i++) begin
            zeros = zeros + {3'b000, ~wr_byte[i]};
        end
        wr_inv = (zeros > 4'd4);
        wr_enc = wr_inv ? ~wr_byte : wr_byte;
        rd_dec = rd_inv ? ~rd_byte : rd_byte;
    end

endmodule

// File: rtl/phy_dq_burst_serdes.sv
// rtl/phy_dq_burst_serdes.sv - DQ/DQS/DM burst serialiser/deserialiser; PHY_DBI_EN enables bus inversion
module phy_dq_burst_serdes
    import phy_pkg::*;
#(
    parameter  int DQ_WIDTH   = 16,
    parameter  int BURST_LEN  = 8,
    parameter  int LAT_WIDTH  = 4,
    localparam int DATA_WIDTH = DQ_WIDTH * BURST_LEN,
    localparam int DM_WIDTH   = DQ_WIDTH / 8,
    localparam int BEAT_W     = $clog2(BURST_LEN)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_write,
    input  logic                          i_bc4,
    input  logic [LAT_WIDTH-1:0]          i_cwl,
    input  logic [LAT_WIDTH-1:0]          i_cl,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    input  logic [BURST_LEN*DM_WIDTH-1:0] i_wr_mask,
    output logic [DQ_WIDTH-1:0]           o_dq_out,
    output logic                          o_dq_oe,
    output logic [DM_WIDTH-1:0]           o_dm_out,
    output logic                          o_dqs_out,
    output logic                          o_dqs_oe,
    input  logic [DQ_WIDTH-1:0]           i_dq_in,
    input  logic [DM_WIDTH-1:0]           i_dbi_in,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic                          o_rd_valid,
    output logic                          o_busy
);

    phy_dq_state_t state;

    logic [BEAT_W-1:0]             beat_cnt;
    logic [BEAT_W-1:0]             nxt_beat;
    logic [BEAT_W-1:0]             last_beat;
    logic [LAT_WIDTH-1:0]          lat_cnt;
    logic [LAT_WIDTH-1:0]          eff_cwl;
    logic [LAT_WIDTH-1:0]          eff_cl;
    logic                          bc4_q;
    logic [DATA_WIDTH-1:0]         wr_data_q;
    logic [BURST_LEN*DM_WIDTH-1:0] wr_mask_q;

    logic [DQ_WIDTH-1:0]           wr_beats [BURST_LEN];
    logic [DM_WIDTH-1:0]           wr_masks [BURST_LEN];
    logic [DQ_WIDTH-1:0]           rd_slots [BURST_LEN];
    logic [DATA_WIDTH-1:0]         rd_next;

    logic [DQ_WIDTH-1:0]           tx_raw;
    logic [DQ_WIDTH-1:0]           tx_dq;
    logic [DM_WIDTH-1:0]           tx_mask;
    logic [DM_WIDTH-1:0]           tx_dm;
    logic [DQ_WIDTH-1:0]           rx_dq;

    assign o_cmd_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);

    assign eff_cwl   = (i_cwl < LAT_WIDTH'(MIN_CWL)) ? LAT_WIDTH'(MIN_CWL) : i_cwl;
    assign eff_cl    = (i_cl < LAT_WIDTH'(MIN_CL)) ? LAT_WIDTH'(MIN_CL) : i_cl;
    assign last_beat = bc4_q ? BEAT_W'(BC4_BEATS - 1) : BEAT_W'(BURST_LEN - 1);

    // Index of the beat that the next clock edge will put on the pins.
    assign nxt_beat = (state == ST_WR_BURST) ? beat_cnt + 1'b1 : '0;
    assign tx_raw   = wr_beats[nxt_beat];
    assign tx_mask  = wr_masks[nxt_beat];

    for (genvar k = 0; k < BURST_LEN; k++) begin : g_beat
        assign wr_beats[k] = wr_data_q[k*DQ_WIDTH +: DQ_WIDTH];
        assign wr_masks[k] = wr_mask_q[k*DM_WIDTH +: DM_WIDTH];
        // The final beat is merged in here so the word can be published on the same edge.
        assign rd_next[k*DQ_WIDTH +: DQ_WIDTH] =
            (beat_cnt == BEAT_W'(k)) ? rx_dq : rd_slots[k];
    end

`ifdef PHY_DBI_EN
    logic mask_unused;
    assign mask_unused = ^tx_mask;

    for (genvar l = 0; l < DM_WIDTH; l++) begin : g_dbi
        phy_dbi_lane u_lane (
            .wr_byte (tx_raw[l*8 +: 8]),
            .wr_enc  (tx_dq[l*8 +: 8]),
            .wr_inv  (tx_dm[l]),
            .rd_byte (i_dq_in[l*8 +: 8]),
            .rd_inv  (i_dbi_in[l]),
            .rd_dec  (rx_dq[l*8 +: 8])
        );
    end
`else
    logic dbi_unused;
    assign dbi_unused = ^i_dbi_in;
    assign tx_dq      = tx_raw;
    assign tx_dm      = tx_mask;
    assign rx_dq      = i_dq_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            lat_cnt    <= '0;
            bc4_q      <= 1'b0;
            wr_data_q  <= '0;
            wr_mask_q  <= '0;
            for (int k = 0; k < BURST_LEN; k++) rd_slots[k] <= '0;
            o_dq_out   <= '0;
            o_dq_oe    <= 1'b0;
            o_dm_out   <= '0;
            o_dqs_out  <= 1'b0;
            o_dqs_oe   <= 1'b0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            o_rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        bc4_q     <= i_bc4;
                        wr_data_q <= i_wr_data;
                        wr_mask_q <= i_wr_mask;
                        beat_cnt  <= '0;
                        if (i_cmd_write) begin
                            if (eff_cwl == LAT_WIDTH'(MIN_CWL)) begin
                                state     <= ST_WR_PRE;
                                o_dqs_oe  <= 1'b1;
                                o_dqs_out <= 1'b0;
                            end else begin
                                state   <= ST_WR_WAIT;
                                lat_cnt <= eff_cwl - LAT_WIDTH'(MIN_CWL);
                            end
                        end else begin
                            // Cleared so that chopped bursts read back zero in the unused slots.
                            for (int k = 0; k < BURST_LEN; k++) rd_slots[k] <= '0;
                            if (eff_cl == LAT_WIDTH'(MIN_CL)) begin
                                state <= ST_RD_CAP;
                            end else begin
                                state   <= ST_RD_WAIT;
                                lat_cnt <= eff_cl - LAT_WIDTH'(MIN_CL);
                            end
                        end
                    end
                end

                ST_WR_WAIT: begin
                    if (lat_cnt <= LAT_WIDTH'(1)) begin
                        state     <= ST_WR_PRE;
                        lat_cnt   <= '0;
                        o_dqs_oe  <= 1'b1;
                        o_dqs_out <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                ST_WR_PRE: begin
                    state     <= ST_WR_BURST;
                    beat_cnt  <= '0;
                    o_dq_oe   <= 1'b1;
                    o_dqs_out <= 1'b1;
                    o_dq_out  <= tx_dq;
                    o_dm_out  <= tx_dm;
                end

                ST_WR_BURST: begin
                    if (beat_cnt == last_beat) begin
                        state     <= ST_WR_POST;
                        beat_cnt  <= '0;
                        o_dq_oe   <= 1'b0;
                        o_dqs_out <= 1'b0;
                        o_dq_out  <= '0;
                        o_dm_out  <= '0;
                    end else begin
                        beat_cnt  <= nxt_beat;
                        o_dqs_out <= ~nxt_beat[0];
                        o_dq_out  <= tx_dq;
                        o_dm_out  <= tx_dm;
                    end
                end

                ST_WR_POST: begin
                    state    <= ST_IDLE;
                    o_dqs_oe <= 1'b0;
                end

                ST_RD_WAIT: begin
                    if (lat_cnt <= LAT_WIDTH'(1)) begin
                        state   <= ST_RD_CAP;
                        lat_cnt <= '0;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                ST_RD_CAP: begin
                    rd_slots[beat_cnt] <= rx_dq;
                    if (beat_cnt == last_beat) begin
                        state      <= ST_IDLE;
                        beat_cnt   <= '0;
                        o_rd_data  <= rd_next;
                        o_rd_valid <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_dq_burst_serdes.sv
// tb/tb_phy_dq_burst_serdes.sv - cycle-timeline scoreboard bench for phy_dq_burst_serdes
module tb_phy_dq_burst_serdes;

    localparam int NC = 4096;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_cmd_valid = 1'b0;
    logic         o_cmd_ready;
    logic         i_cmd_write = 1'b0;
    logic         i_bc4 = 1'b0;
    logic [3:0]   i_cwl = 4'd0;
    logic [3:0]   i_cl = 4'd0;
    logic [127:0] i_wr_data = '0;
    logic [15:0]  i_wr_mask = '0;
    logic [15:0]  o_dq_out;
    logic         o_dq_oe;
    logic [1:0]   o_dm_out;
    logic         o_dqs_out;
    logic         o_dqs_oe;
    logic [15:0]  i_dq_in = 16'hBEEF;
    logic [1:0]   i_dbi_in = 2'b11;
    logic [127:0] o_rd_data;
    logic         o_rd_valid;
    logic         o_busy;

    phy_dq_burst_serdes #(.DQ_WIDTH(16), .BURST_LEN(8), .LAT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_write(i_cmd_write), .i_bc4(i_bc4),
        .i_cwl(i_cwl), .i_cl(i_cl),
        .i_wr_data(i_wr_data), .i_wr_mask(i_wr_mask),
        .o_dq_out(o_dq_out), .o_dq_oe(o_dq_oe), .o_dm_out(o_dm_out),
        .o_dqs_out(o_dqs_out), .o_dqs_oe(o_dqs_oe),
        .i_dq_in(i_dq_in), .i_dbi_in(i_dbi_in),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected pin timeline, indexed by absolute cycle number; absent entries mean 0.
    bit         e_busy  [NC];
    bit         e_dq_oe [NC];
    bit         e_dqs_oe[NC];
    bit         e_dqs   [NC];
    bit [15:0]  e_dq    [NC];
    bit [1:0]   e_dm    [NC];
    bit         e_rv    [NC];
    bit         e_rupd  [NC];
    bit [127:0] e_rval  [NC];
    bit         d_en    [NC];
    bit [15:0]  d_dq    [NC];
    bit [1:0]   d_dbi   [NC];

    int         free_at = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    bit         chk_en = 1'b0;
    bit [127:0] exp_rd = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit [8:0] enc_byte(input bit [7:0] b);
        if ($countones(b) < 4) return {1'b1, ~b};
        return {1'b0, b};
    endfunction

    function automatic bit [17:0] tx_model(input bit [15:0] d, input bit [1:0] m);
`ifdef PHY_DBI_EN
        bit [8:0] e0, e1;
        e0 = enc_byte(d[7:0]);
        e1 = enc_byte(d[15:8]);
        return {e1[8], e0[8], e1[7:0], e0[7:0]};
`else
        return {m, d};
`endif
    endfunction

    function automatic bit [15:0] rx_model(input bit [15:0] d, input bit [1:0] f);
`ifdef PHY_DBI_EN
        return {f[1] ? ~d[15:8] : d[15:8], f[0] ? ~d[7:0] : d[7:0]};
`else
        return d;
`endif
    endfunction

    always @(posedge clk) begin
        #1;
        if (d_en[cyc]) begin
            i_dq_in  = d_dq[cyc];
            i_dbi_in = d_dbi[cyc];
        end else begin
            i_dq_in  = 16'hBEEF;
            i_dbi_in = 2'b11;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (e_rupd[cyc]) exp_rd = e_rval[cyc];
            chk("cmd_ready", o_cmd_ready, !e_busy[cyc]);
            chk("busy", o_busy, e_busy[cyc]);
            chk("dq_oe", o_dq_oe, e_dq_oe[cyc]);
            chk("dqs_oe", o_dqs_oe, e_dqs_oe[cyc]);
            chk("dqs_out", o_dqs_out, e_dqs[cyc]);
            chk("dq_out", o_dq_out, e_dq[cyc]);
            chk("dm_out", o_dm_out, e_dm[cyc]);
            chk("rd_valid", o_rd_valid, e_rv[cyc]);
            chk("rd_data", o_rd_data, exp_rd);
        end
    end

    task automatic cmd(input bit wr, input bit bc4, input int lat, input bit [127:0] data,
                       input bit [15:0] mask, input bit [127:0] rbeats, input bit [15:0] rdbi,
                       output int t);
        int guard = 0;
        int n;
        int c;
        bit [127:0] word;
        bit [17:0] e;
        while (cyc < free_at && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) chk("cmd_wait_bound", 1'b1, 1'b0);
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_bc4       = bc4;
        i_cwl       = wr ? 4'(lat) : 4'hF;
        i_cl        = wr ? 4'hF : 4'(lat);
        i_wr_data   = data;
        i_wr_mask   = mask;
        t = cyc;
        n = bc4 ? 4 : 8;
        if (wr) begin
            c = (lat < 2) ? 2 : lat;
            for (int j = t + 1; j <= t + c + n; j++) e_busy[j] = 1'b1;
            e_dqs_oe[t + c - 1] = 1'b1;
            for (int k = 0; k < n; k++) begin
                e = tx_model(data[k*16 +: 16], mask[k*2 +: 2]);
                e_dq_oe[t + c + k]  = 1'b1;
                e_dqs_oe[t + c + k] = 1'b1;
                e_dqs[t + c + k]    = (k % 2 == 0);
                e_dq[t + c + k]     = e[15:0];
                e_dm[t + c + k]     = e[17:16];
            end
            e_dqs_oe[t + c + n] = 1'b1;
            free_at = t + c + n + 1;
        end else begin
            c = (lat < 1) ? 1 : lat;
            word = '0;
            for (int j = t + 1; j <= t + c + n - 1; j++) e_busy[j] = 1'b1;
            for (int k = 0; k < n; k++) begin
                d_en[t + c + k]  = 1'b1;
                d_dq[t + c + k]  = rbeats[k*16 +: 16];
                d_dbi[t + c + k] = rdbi[k*2 +: 2];
                word[k*16 +: 16] = rx_model(rbeats[k*16 +: 16], rdbi[k*2 +: 2]);
            end
            e_rv[t + c + n]   = 1'b1;
            e_rupd[t + c + n] = 1'b1;
            e_rval[t + c + n] = word;
            free_at = t + c + n;
        end
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        i_cmd_write = ~wr;
        i_bc4       = ~bc4;
        i_cwl       = 4'hF;
        i_cl        = 4'hF;
        i_wr_data   = ~data;
        i_wr_mask   = ~mask;
    endtask

    task automatic do_reset();
        int r;
        r = cyc;
        rst = 1'b1;
        for (int j = r + 1; j < NC; j++) begin
            e_busy[j] = 0; e_dq_oe[j] = 0; e_dqs_oe[j] = 0; e_dqs[j] = 0;
            e_dq[j] = '0; e_dm[j] = '0; e_rv[j] = 0; e_rupd[j] = 0; e_rval[j] = '0;
            d_en[j] = 0;
        end
        e_rupd[r + 1] = 1'b1;
        free_at = r + 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic at(input int n);
        int g = 0;
        @(negedge clk);
        while (cyc < n && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("at_bound", 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, t2;
        bit [127:0] d;
        bit [127:0] rb;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        at(cyc);
        chk("reset_ready", o_cmd_ready, 1'b1);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_rd_data", o_rd_data, 128'h0);
        chk("reset_oe", {o_dq_oe, o_dqs_oe, o_rd_valid}, 3'b000);

        // Write, cwl 5, beat k = k
        d = '0;
        for (int k = 0; k < 8; k++) d[k*16 +: 16] = 16'(k);
        cmd(1'b1, 1'b0, 5, d, 16'h0000, '0, '0, t);
        at(t + 4);
        chk("t1_preamble", {o_dqs_oe, o_dqs_out, o_dq_oe}, 3'b100);
        at(t + 5);
        chk("t1_beat0_ctl", {o_dq_oe, o_dqs_out}, 2'b11);
`ifdef PHY_DBI_EN
        chk("t1_beat0", o_dq_out, 16'hFFFF);
`else
        chk("t1_beat0", o_dq_out, 16'h0000);
`endif
        at(t + 6);
        chk("t1_beat1_dqs", o_dqs_out, 1'b0);
        at(t + 12);
`ifdef PHY_DBI_EN
        chk("t1_beat7", o_dq_out, 16'hFFF8);
`else
        chk("t1_beat7", o_dq_out, 16'h0007);
`endif
        at(t + 13);
        chk("t1_postamble", {o_dqs_oe, o_dqs_out, o_dq_oe}, 3'b100);
        at(t + 14);
        chk("t1_ready", o_cmd_ready, 1'b1);

        // Read, cl 3, beat k = 0xA0 + k
        rb = '0;
        for (int k = 0; k < 8; k++) rb[k*16 +: 16] = 16'(8'hA0 + k);
        cmd(1'b0, 1'b0, 3, '0, '0, rb, 16'h0000, t);
        at(t + 10);
        chk("t2_no_early_valid", o_rd_valid, 1'b0);
        at(t + 11);
        chk("t2_valid", o_rd_valid, 1'b1);
        chk("t2_data", o_rd_data, 128'h00A7_00A6_00A5_00A4_00A3_00A2_00A1_00A0);

        // BC4 write with cwl 0 (clamped)
        cmd(1'b1, 1'b1, 0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'h5A3E, '0, '0, t);
        at(t + 1);
        chk("t3_preamble", {o_dqs_oe, o_dq_oe}, 2'b10);
        at(t + 2);
`ifndef PHY_DBI_EN
        chk("t3_dm_beat0", o_dm_out, 2'b10);
`endif
        at(t + 5);
        chk("t3_beat3_oe", o_dq_oe, 1'b1);
        at(t + 6);
        chk("t3_post", {o_dqs_oe, o_dq_oe}, 2'b10);

        // BC4 read, cl 1
        cmd(1'b0, 1'b1, 1, '0, '0, 128'h8888_7777_6666_5555_4444_3333_2222_1111, 16'h0000, t);
        at(t + 5);
        chk("t3_rd_valid", o_rd_valid, 1'b1);
        chk("t3_rd_data", o_rd_data, 128'h0000_0000_0000_0000_4444_3333_2222_1111);

        // Read followed by write accepted on the valid cycle
        rb = '0;
        for (int k = 0; k < 8; k++) rb[k*16 +: 16] = 16'(16'h3C00 + k * 16'h0111);
        cmd(1'b0, 1'b0, 2, '0, '0, rb, 16'h0000, t);
        cmd(1'b1, 1'b0, 2, 128'hFFFF_0F0F_00FF_F00F_1357_9BDF_2468_ACE0, 16'hC3A5, '0, '0, t2);
        chk("t4_b2b_accept", t2, t + 10);
        at(t2 + 11);

        // Reset during beat 3 of a read
        cmd(1'b0, 1'b0, 2, '0, '0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h0000, t);
        at(t + 5);
        do_reset();
        at(t + 6);
        chk("t5_rst_valid", o_rd_valid, 1'b0);
        chk("t5_rst_ready", o_cmd_ready, 1'b1);
        chk("t5_rst_data", o_rd_data, 128'h0);
        at(t + 10);
        chk("t5_no_valid", o_rd_valid, 1'b0);

        cmd(1'b1, 1'b0, 3, 128'hDEAD_BEEF_CAFE_F00D_0BAD_F1E1_D5EA_A55A, 16'h0F0F, '0, '0, t);
        at(t + 13);

`ifdef PHY_DBI_EN
        cmd(1'b1, 1'b0, 2, 128'h0000_0000_0000_0000_0000_0000_0000_FF01, 16'h0000, '0, '0, t);
        at(t + 2);
        chk("t6_dbi_dq", o_dq_out, 16'hFFFE);
        chk("t6_dbi_dm", o_dm_out, 2'b01);
        cmd(1'b0, 1'b0, 1, '0, '0, 128'h0000_0000_0000_0000_0000_0000_0000_00FE, 16'h0001, t);
        at(t + 9);
        chk("t6_dbi_rd", o_rd_data[15:0], 16'h0001);
`endif

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
